// File: rtl/stage_mem_pipe.sv
// stage_mem_pipe: WIDTH x DEPTH storage with a free-running write port and a credit-limited, pipelined read port
// Optional feature macro: STAGE_MEM_BYPASS_EN (forward same-cycle write data to a colliding accepted read).
// Ports:
//   clk                                      clock, rising edge
//   reset                                    asynchronous, active-low
//   wr_valid, wr_addr, wr_data               write port, out-of-range addresses ignored
//   rd_req_valid, rd_req_ready, rd_req_addr  read request handshake
//   rd_rsp_valid, rd_rsp_ready, rd_rsp_data  in-order read response handshake
//   rd_pending                               reads in flight (s1 stage + response FIFO)
module stage_mem_pipe #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_req_valid,
  output logic              rd_req_ready,
  input  logic [ADDR_W-1:0] rd_req_addr,
  output logic              rd_rsp_valid,
  input  logic              rd_rsp_ready,
  output logic [WIDTH-1:0]  rd_rsp_data,
  output logic [1:0]        rd_pending
);
  localparam logic [ADDR_W:0] depth_l = (ADDR_W+1)'(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] fifo [3];
  logic [WIDTH-1:0] rd_word, s1_data;
  logic [1:0] wp, rp, cnt;
  logic wr_in, rd_in, rd_acc, s1_valid, push, pop;
  assign wr_in = {1'b0, wr_addr} < depth_l;
  assign rd_in = {1'b0, rd_req_addr} < depth_l;
  // Credit counts everything accepted but not yet consumed, so the FIFO can never overflow
  assign rd_pending = {1'b0, s1_valid} + cnt;
  assign rd_req_ready = rd_pending != 2'd3;
  assign rd_acc = rd_req_valid && rd_req_ready;
  assign push = s1_valid;
  assign rd_rsp_valid = cnt != 2'd0;
  assign pop = rd_rsp_valid && rd_rsp_ready;
  assign rd_rsp_data = rd_rsp_valid ? fifo[rp] : '0;
`ifdef STAGE_MEM_BYPASS_EN
  assign rd_word = !rd_in ? '0 : (wr_valid && wr_addr == rd_req_addr) ? wr_data : mem[rd_req_addr];
`else
  assign rd_word = rd_in ? mem[rd_req_addr] : '0;
`endif
  // Storage is deliberately outside reset so contents survive it
  always_ff @(posedge clk)
    if (wr_valid && wr_in) mem[wr_addr] <= wr_data;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_data <= '0;
    end else begin
      s1_valid <= rd_acc;
      if (rd_acc) s1_data <= rd_word;
    end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      fifo <= '{default: '0};
      wp <= 2'd0;
      rp <= 2'd0;
      cnt <= 2'd0;
    end else begin
      if (push) fifo[wp] <= s1_data;
      if (push) wp <= wp == 2'd2 ? 2'd0 : wp + 2'd1;
      if (pop) rp <= rp == 2'd2 ? 2'd0 : rp + 2'd1;
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
    end
  assert property (@(posedge clk) disable iff (!reset) !(push && cnt == 2'd3));
endmodule
